dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the CPU MEM stage and an external requester (program loader / debug port).
- Chooses one winner per cycle and drives the data memory control inputs: mem_read, mem_write, addr, write_data.
- Stalls the CPU whenever it loses arbitration.
- CPU has fixed priority. A starvation counter and a locked-burst mode guarantee progress for the external port.

---
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU MEM stage and an external port.
// Optional statistics outputs are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_cpu_stall_cnt,
  output logic [31:0]       stat_ext_grant_cnt
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

  typedef enum logic {
    S_CPU       = 1'b0,
    S_EXT_BURST = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_nxt;
  logic [BW-1:0] r_burst_cnt;
  logic [BW-1:0] w_burst_nxt;
  logic          w_cpu_win;
  logic          w_ext_win;

  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ext_rdata;
  logic              r_cpu_rvalid;
  logic              r_ext_rvalid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_CPU;
      r_starve_cnt <= '0;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_burst_cnt  <= w_burst_nxt;
    end
  end

  // CPU holds fixed priority in S_CPU until the external port has starved long enough.
  always_comb begin
    w_cpu_win   = 1'b0;
    w_ext_win   = 1'b0;
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      S_CPU: begin
        if (cpu_req && (r_starve_cnt < STARVE_LIM)) begin
          w_cpu_win = 1'b1;
        end else if (ext_req) begin
          w_ext_win = 1'b1;
        end
        if (w_ext_win && ext_lock) begin
          w_state_nxt = S_EXT_BURST;
          w_burst_nxt = BW'(1);
        end
      end
      S_EXT_BURST: begin
        w_ext_win = ext_req;
        if (!ext_lock || (r_burst_cnt == BURST_LIM)) begin
          w_state_nxt = S_CPU;
          w_burst_nxt = '0;
        end else begin
          w_burst_nxt = r_burst_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_CPU;
        w_burst_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_starve_nxt = '0;
    if (ext_req && !w_ext_win) begin
      w_starve_nxt = (r_starve_cnt < STARVE_LIM) ? r_starve_cnt + 1'b1 : r_starve_cnt;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (w_cpu_win) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_read  = ~cpu_we;
      mem_write = cpu_we;
    end else if (w_ext_win) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_read  = ~ext_we;
      mem_write = ext_we;
    end
  end

  assign cpu_stall = cpu_req & ~w_cpu_win;
  assign ext_gnt   = w_ext_win;

  // Read data is captured at the grant edge; each port owns its own return register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cpu_rdata  <= '0;
      r_ext_rdata  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_ext_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_win & ~cpu_we;
      r_ext_rvalid <= w_ext_win & ~ext_we;
      if (w_cpu_win && !cpu_we) begin
        r_cpu_rdata <= mem_rdata;
      end
      if (w_ext_win && !ext_we) begin
        r_ext_rdata <= mem_rdata;
      end
    end
  end

  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_rvalid = r_cpu_rvalid;
  assign ext_rdata  = r_ext_rdata;
  assign ext_rvalid = r_ext_rvalid;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_cpu_stall_cnt;
  logic [31:0] r_stat_ext_grant_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stat_cpu_stall_cnt <= '0;
      r_stat_ext_grant_cnt <= '0;
    end else begin
      if (cpu_stall) begin
        r_stat_cpu_stall_cnt <= r_stat_cpu_stall_cnt + 32'd1;
      end
      if (ext_gnt) begin
        r_stat_ext_grant_cnt <= r_stat_ext_grant_cnt + 32'd1;
      end
    end
  end

  assign stat_cpu_stall_cnt = r_stat_cpu_stall_cnt;
  assign stat_ext_grant_cnt = r_stat_ext_grant_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        ext_req;
  logic        ext_we;
  logic        ext_lock;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic [31:0] ext_rdata;
  logic        ext_rvalid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_cpu_stall_cnt;
  logic [31:0] stat_ext_grant_cnt;
`endif

  int testsRun;
  int failCount;

  logic        memLoad;
  logic [31:0] memArray [0:63];

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .BURST_MAX(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_cpu_stall_cnt(stat_cpu_stall_cnt), .stat_ext_grant_cnt(stat_ext_grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory: combinational read, write at the grant edge.
  assign mem_rdata = memArray[mem_addr[7:2]];

  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < 64; i++) memArray[i] <= 32'h0;
      memArray[4] <= 32'hDEADBEEF;
    end else if (mem_write) begin
      memArray[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                               input logic [31:0] cWdata, input logic eReq, input logic eWe,
                               input logic eLock, input logic [31:0] eAddr,
                               input logic [31:0] eWdata);
    @(negedge clk);
    cpu_req   = cReq;
    cpu_we    = cWe;
    cpu_addr  = cAddr;
    cpu_wdata = cWdata;
    ext_req   = eReq;
    ext_we    = eWe;
    ext_lock  = eLock;
    ext_addr  = eAddr;
    ext_wdata = eWdata;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    memLoad   = 1'b1;
    reset_n   = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    ext_req = 1'b0; ext_we = 1'b0; ext_lock = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0;

    // Reset state
    applyIdle();
    applyIdle();
    checkOutput("rst_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
    checkOutput("rst_ext_rvalid", {31'h0, ext_rvalid}, 32'h0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 32'h0);
    checkOutput("rst_ext_rdata", ext_rdata, 32'h0);
    checkOutput("rst_ext_gnt", {31'h0, ext_gnt}, 32'h0);
    memLoad = 1'b0;
    reset_n = 1'b1;

    // CPU-only read of the preloaded word
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("cpu_rd_stall", {31'h0, cpu_stall}, 32'h0);
    checkOutput("cpu_rd_mem_read", {31'h0, mem_read}, 32'h1);
    checkOutput("cpu_rd_mem_addr", mem_addr, 32'h10);
    applyIdle();
    checkOutput("cpu_rd_rvalid", {31'h0, cpu_rvalid}, 32'h1);
    checkOutput("cpu_rd_rdata", cpu_rdata, 32'hDEADBEEF);
    checkOutput("cpu_rd_ext_rvalid", {31'h0, ext_rvalid}, 32'h0);
    applyIdle();
    checkOutput("cpu_rd_rvalid_drop", {31'h0, cpu_rvalid}, 32'h0);
    checkOutput("cpu_rd_rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // Contention: ext wins every fifth cycle
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'h30, 32'hA5A5A5A5);
      checkOutput("contend_ext_gnt", {31'h0, ext_gnt}, {31'h0, (c % 5 == 0)});
      checkOutput("contend_cpu_stall", {31'h0, cpu_stall}, {31'h0, (c % 5 == 0)});
      if (c == 5) begin
        checkOutput("contend_mem_write", {31'h0, mem_write}, 32'h1);
        checkOutput("contend_mem_addr", mem_addr, 32'h30);
        checkOutput("contend_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        checkOutput("contend_rvalid_c5", {31'h0, cpu_rvalid}, 32'h1);
      end
      if (c == 6) checkOutput("contend_rvalid_c6", {31'h0, cpu_rvalid}, 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyIdle();
    checkOutput("contend_readback", cpu_rdata, 32'hA5A5A5A5);

    // Locked burst of three writes after starvation forces ext in
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h1);
      checkOutput("lock_pre_stall", {31'h0, cpu_stall}, 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h1);
    checkOutput("lock_w1_gnt", {31'h0, ext_gnt}, 32'h1);
    checkOutput("lock_w1_stall", {31'h0, cpu_stall}, 32'h1);
    checkOutput("lock_w1_wdata", mem_wdata, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 32'h4, 32'h2);
    checkOutput("lock_w2_gnt", {31'h0, ext_gnt}, 32'h1);
    checkOutput("lock_w2_stall", {31'h0, cpu_stall}, 32'h1);
    checkOutput("lock_w2_addr", mem_addr, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h3);
    checkOutput("lock_w3_gnt", {31'h0, ext_gnt}, 32'h1);
    checkOutput("lock_w3_stall", {31'h0, cpu_stall}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("lock_after_stall", {31'h0, cpu_stall}, 32'h0);
    checkOutput("lock_after_addr", mem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("lock_mem0", cpu_rdata, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("lock_mem4", cpu_rdata, 32'h2);
    applyIdle();
    checkOutput("lock_mem8", cpu_rdata, 32'h3);

    // Burst timeout: lock held for 20 cycles, CPU back in after 16 burst cycles
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    checkOutput("tmo_enter_gnt", {31'h0, ext_gnt}, 32'h1);
    for (int c = 1; c <= 19; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
      checkOutput("tmo_ext_gnt", {31'h0, ext_gnt}, {31'h0, (c <= 16)});
      checkOutput("tmo_cpu_stall", {31'h0, cpu_stall}, {31'h0, (c <= 16)});
      if (c == 17) begin
        checkOutput("tmo_ext_rvalid_last", {31'h0, ext_rvalid}, 32'h1);
        checkOutput("tmo_ext_rdata", ext_rdata, 32'hDEADBEEF);
        checkOutput("tmo_cpu_rvalid_17", {31'h0, cpu_rvalid}, 32'h0);
      end
      if (c == 18) begin
        checkOutput("tmo_cpu_rvalid_18", {31'h0, cpu_rvalid}, 32'h1);
        checkOutput("tmo_ext_rvalid_18", {31'h0, ext_rvalid}, 32'h0);
        checkOutput("tmo_cpu_rdata", cpu_rdata, 32'h3);
      end
    end
    applyIdle();

    // Reset asserted in the second burst cycle
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    checkOutput("rstb_enter_gnt", {31'h0, ext_gnt}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    checkOutput("rstb_c2_stall", {31'h0, cpu_stall}, 32'h1);
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    reset_n = 1'b1;
    checkOutput("rstb_cpu_stall", {31'h0, cpu_stall}, 32'h0);
    checkOutput("rstb_ext_gnt", {31'h0, ext_gnt}, 32'h0);
    checkOutput("rstb_mem_addr", mem_addr, 32'h4);
    checkOutput("rstb_ext_rvalid", {31'h0, ext_rvalid}, 32'h0);
    checkOutput("rstb_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h0);
    checkOutput("rstb_ext_rdata", ext_rdata, 32'h0);
    applyIdle();
    checkOutput("rstb_cpu_rvalid_after", {31'h0, cpu_rvalid}, 32'h1);
    checkOutput("rstb_cpu_rdata_after", cpu_rdata, 32'h2);

    // Idle cycles drive nothing
    for (int c = 1; c <= 5; c++) begin
      applyIdle();
      checkOutput("idle_mem_read", {31'h0, mem_read}, 32'h0);
      checkOutput("idle_mem_write", {31'h0, mem_write}, 32'h0);
      checkOutput("idle_mem_addr", mem_addr, 32'h0);
      checkOutput("idle_ext_gnt", {31'h0, ext_gnt}, 32'h0);
      checkOutput("idle_rvalids", {30'h0, cpu_rvalid, ext_rvalid}, 32'h0);
    end

    // Starvation count starts from zero after idle
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h5A5A5A5A);
      checkOutput("idle_starve_gnt", {31'h0, ext_gnt}, {31'h0, (c == 5)});
    end
    applyIdle();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
